// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-boundary double buffering.
// Optional anode dead time at the start of each slot: define SSD_DEADTIME_EN.
module ssd_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

`ifdef SSD_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                wrap_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                tick_q;
  logic                slot_end, frame_end, en_cur;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (presc_q == LAST_CNT);
    frame_end = slot_end && (idx_q == LAST_IDX);
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the pending stage.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
    if (frame_end) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp_in : pend_dp_q;
    end
  end

  always_comb begin
    nib    = disp_val_q[4*idx_q +: 4];
    en_cur = digit_en[idx_q];
    an_d   = en_cur ? ~(DIGITS'(1) << idx_q) : '1;
    // Constant-false in the default build, so the comparator folds away.
    if (DEAD_EN && (presc_q < PW'(DEAD_CYCLES))) begin
      an_d = '1;
    end
    seg_d = en_cur ? hex7(nib) : '1;
    dp_d  = ~(disp_dp_q[idx_q] & en_cur);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      wrap_q     <= 1'b0;
      an_q       <= '1;
      seg_q      <= '1;
      dp_q       <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      wrap_q     <= frame_end;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      tick_q     <= wrap_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
